// File: rtl/uc_movimenta_asteroides_e_tiros_if.sv
// Interface between the asteroid/shot movement sub-FSM and the rest of the game.
// master : the sequencing UC (drives addresses, write/deactivate pulses, fim, db_estado)
// slave  : main UC + datapath side (drives inicia and the RAM status flags)
interface uc_movimenta_asteroides_e_tiros_if #(
   parameter int unsigned W_AST  = 4,
   parameter int unsigned W_TIRO = 2
) ();
   logic              inicia;
   logic              tiro_ativo;
   logic              tiro_fora_tela;
   logic              asteroide_ativo;
   logic              colisao_nave;
   logic              colisao_tiro_ast;
   logic [W_TIRO-1:0] addr_tiro;
   logic [W_AST-1:0]  addr_asteroide;
   logic              we_tiro;
   logic              we_asteroide;
   logic              desativa_tiro;
   logic              desativa_asteroide;
   logic              decrementa_vida;
   logic              incrementa_pontos;
   logic              fim;
   logic [4:0]        db_estado;

   modport master (
      input  inicia, tiro_ativo, tiro_fora_tela, asteroide_ativo, colisao_nave,
             colisao_tiro_ast,
      output addr_tiro, addr_asteroide, we_tiro, we_asteroide, desativa_tiro,
             desativa_asteroide, decrementa_vida, incrementa_pontos, fim, db_estado
   );

   modport slave (
      output inicia, tiro_ativo, tiro_fora_tela, asteroide_ativo, colisao_nave,
             colisao_tiro_ast,
      input  addr_tiro, addr_asteroide, we_tiro, we_asteroide, desativa_tiro,
             desativa_asteroide, decrementa_vida, incrementa_pontos, fim, db_estado
   );
endinterface

// File: rtl/uc_movimenta_asteroides_e_tiros.sv
// Sub-FSM that sequences one frame of shot/asteroid movement and collision handling.
// Walks the shot RAM, then the asteroid RAM, then every asteroid x shot pair, issuing
// one-cycle write/deactivate pulses decoded from the current state and datapath flags.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-low
//   bus    - master side of uc_movimenta_asteroides_e_tiros_if (inicia, status flags in;
//            RAM addresses, pulses, fim and db_estado out)
module uc_movimenta_asteroides_e_tiros #(
   parameter int unsigned N_AST  = 16,
   parameter int unsigned W_AST  = 4,
   parameter int unsigned N_TIRO = 4,
   parameter int unsigned W_TIRO = 2
) (
   input logic                                  clock,
   input logic                                  reset,
   uc_movimenta_asteroides_e_tiros_if.master    bus
);

   typedef enum logic [4:0] {
      StInicial    = 5'h00,
      StPrepara    = 5'h01,
      StLeTiro     = 5'h02,
      StAvaliaTiro = 5'h03,
      StProxTiro   = 5'h04,
      StLeAst      = 5'h05,
      StAvaliaAst  = 5'h06,
      StProxAst    = 5'h07,
      StLePar      = 5'h08,
      StAvaliaPar  = 5'h09,
      StProxPar    = 5'h0A,
      StFim        = 5'h0B
   } state_e;

   localparam logic [W_TIRO-1:0] TiroMax = W_TIRO'(N_TIRO - 1);
   localparam logic [W_AST-1:0]  AstMax  = W_AST'(N_AST - 1);

   state_e            state_q, state_d;
   logic [W_TIRO-1:0] addr_tiro_q, addr_tiro_d;
   logic [W_AST-1:0]  addr_ast_q, addr_ast_d;

   logic we_tiro, we_ast, des_tiro, des_ast, dec_vida, inc_pontos, fim;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StInicial;
         addr_tiro_q <= '0;
         addr_ast_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_tiro_q <= addr_tiro_d;
         addr_ast_q  <= addr_ast_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_tiro_d = addr_tiro_q;
      addr_ast_d  = addr_ast_q;
      we_tiro     = 1'b0;
      we_ast      = 1'b0;
      des_tiro    = 1'b0;
      des_ast     = 1'b0;
      dec_vida    = 1'b0;
      inc_pontos  = 1'b0;
      fim         = 1'b0;
      case (state_q)
         StInicial: begin
            if (bus.inicia) state_d = StPrepara;
         end
         StPrepara: begin
            addr_tiro_d = '0;
            addr_ast_d  = '0;
            state_d     = StLeTiro;
         end
         StLeTiro: state_d = StAvaliaTiro;
         StAvaliaTiro: begin
            // An off-screen shot is retired instead of moved.
            if (bus.tiro_ativo && bus.tiro_fora_tela) des_tiro = 1'b1;
            else if (bus.tiro_ativo)                  we_tiro  = 1'b1;
            state_d = StProxTiro;
         end
         StProxTiro: begin
            if (addr_tiro_q == TiroMax) begin
               addr_tiro_d = '0;
               state_d     = StLeAst;
            end else begin
               addr_tiro_d = addr_tiro_q + 1'b1;
               state_d     = StLeTiro;
            end
         end
         StLeAst: state_d = StAvaliaAst;
         StAvaliaAst: begin
            // A ship hit destroys the asteroid, so it is not moved.
            if (bus.asteroide_ativo && bus.colisao_nave) begin
               des_ast  = 1'b1;
               dec_vida = 1'b1;
            end else if (bus.asteroide_ativo) begin
               we_ast = 1'b1;
            end
            state_d = StProxAst;
         end
         StProxAst: begin
            if (addr_ast_q == AstMax) begin
               addr_ast_d = '0;
               state_d    = StLePar;
            end else begin
               addr_ast_d = addr_ast_q + 1'b1;
               state_d    = StLeAst;
            end
         end
         StLePar: state_d = StAvaliaPar;
         StAvaliaPar: begin
            if (bus.asteroide_ativo && bus.tiro_ativo && bus.colisao_tiro_ast) begin
               des_ast    = 1'b1;
               des_tiro   = 1'b1;
               inc_pontos = 1'b1;
            end
            state_d = StProxPar;
         end
         StProxPar: begin
            // Shot index is the inner loop, asteroid index the outer one.
            state_d = StLePar;
            if (addr_tiro_q == TiroMax) begin
               addr_tiro_d = '0;
               if (addr_ast_q == AstMax) begin
                  addr_ast_d = '0;
                  state_d    = StFim;
               end else begin
                  addr_ast_d = addr_ast_q + 1'b1;
               end
            end else begin
               addr_tiro_d = addr_tiro_q + 1'b1;
            end
         end
         StFim: begin
            fim     = 1'b1;
            state_d = StInicial;
         end
         default: state_d = StInicial;
      endcase
   end

   assign bus.addr_tiro          = addr_tiro_q;
   assign bus.addr_asteroide     = addr_ast_q;
   assign bus.we_tiro            = we_tiro;
   assign bus.we_asteroide       = we_ast;
   assign bus.desativa_tiro      = des_tiro;
   assign bus.desativa_asteroide = des_ast;
   assign bus.decrementa_vida    = dec_vida;
   assign bus.incrementa_pontos  = inc_pontos;
   assign bus.fim                = fim;
   assign bus.db_estado          = state_q;

endmodule
